// File: rtl/branch_predictor_2bit.sv
// -----------------------------------------------------------------------------
// branch_predictor_2bit
// Dynamic branch predictor for the 3-stage core. A table of 2-bit saturating
// counters, indexed by PC, gives a same-cycle guess for the stage-1 branch.
// That guess is carried into stage 2 and the table is trained when stage 2
// resolves the branch. Also keeps the branch / correct-guess statistics
// counters read through MMIO.
//
// Ports:
//   clk, rst            core clock, async active-high reset
//   bp_enable           0 = always guess not-taken and freeze training
//   stall               freezes every register in the block
//   flush               stage-1 instruction killed; zeroes the carried guess
//   pc_guess            stage-1 PC
//   is_br_guess         stage-1 instruction is a conditional branch
//   br_pred_taken       combinational guess for stage 1
//   br_pred_taken_q     guess belonging to the stage-2 instruction
//   pc_check            stage-2 PC
//   is_br_check         stage-2 instruction is a conditional branch
//   br_taken_check      resolved outcome of the stage-2 branch
//   mispredict          stage-2 guess was wrong
//   cnt_clr             synchronous clear of both statistics counters
//   br_instr_counter    branches resolved
//   correct_br_counter  branches whose guess matched the outcome
// -----------------------------------------------------------------------------
module branch_predictor_2bit #(
   parameter int LINES   = 32,
   parameter int IDX_LSB = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bp_enable,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] pc_guess,
   input  logic        is_br_guess,
   output logic        br_pred_taken,
   output logic        br_pred_taken_q,
   input  logic [31:0] pc_check,
   input  logic        is_br_check,
   input  logic        br_taken_check,
   output logic        mispredict,
   input  logic        cnt_clr,
   output logic [31:0] br_instr_counter,
   output logic [31:0] correct_br_counter
);

   localparam int IDX_W = $clog2(LINES);

   logic [1:0]       table_q [LINES];
   logic [IDX_W-1:0] guess_idx;
   logic [IDX_W-1:0] check_idx;
   logic [1:0]       entry_chk;
   logic [1:0]       entry_d;
   logic             train_en;
   logic             pred_taken_d;
   logic [31:0]      br_instr_cnt_q;
   logic [31:0]      br_instr_cnt_d;
   logic [31:0]      correct_cnt_q;
   logic [31:0]      correct_cnt_d;
   logic             guess_ok;

   assign guess_idx = pc_guess[IDX_LSB +: IDX_W];
   assign check_idx = pc_check[IDX_LSB +: IDX_W];

   // Guess reads the pre-edge table; no bypass from a same-cycle update.
   assign br_pred_taken = bp_enable & is_br_guess & table_q[guess_idx][1];

   assign guess_ok   = (br_taken_check == br_pred_taken_q);
   assign mispredict = bp_enable & is_br_check & ~guess_ok;

   // Training: saturating increment on taken, decrement on not-taken.
   assign entry_chk = table_q[check_idx];
   assign train_en  = ~stall & bp_enable & is_br_check;

   always_comb begin
      entry_d = entry_chk;
      if (br_taken_check) begin
         if (entry_chk != 2'b11) entry_d = entry_chk + 2'b01;
      end else begin
         if (entry_chk != 2'b00) entry_d = entry_chk - 2'b01;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LINES; i++) table_q[i] <= 2'b01;
      end else if (train_en) begin
         table_q[check_idx] <= entry_d;
      end
   end

   // Carried guess; stall outranks flush.
   always_comb begin
      pred_taken_d = br_pred_taken_q;
      if (!stall) begin
         if (flush) pred_taken_d = 1'b0;
         else       pred_taken_d = br_pred_taken;
      end
   end

   // Statistics counters; clear outranks counting, both wrap mod 2^32.
   always_comb begin
      br_instr_cnt_d = br_instr_cnt_q;
      correct_cnt_d  = correct_cnt_q;
      if (!stall) begin
         if (cnt_clr) begin
            br_instr_cnt_d = '0;
            correct_cnt_d  = '0;
         end else if (is_br_check) begin
            br_instr_cnt_d = br_instr_cnt_q + 32'd1;
            if (guess_ok) correct_cnt_d = correct_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_pred_taken_q <= 1'b0;
         br_instr_cnt_q  <= '0;
         correct_cnt_q   <= '0;
      end else begin
         br_pred_taken_q <= pred_taken_d;
         br_instr_cnt_q  <= br_instr_cnt_d;
         correct_cnt_q   <= correct_cnt_d;
      end
   end

   assign br_instr_counter   = br_instr_cnt_q;
   assign correct_br_counter = correct_cnt_q;

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_2bit
// Directed bench for branch_predictor_2bit (LINES=32, IDX_LSB=2). Inputs are
// driven on the falling edge, outputs sampled 1ns later, so every sample sits
// half a period away from the rising edge.
// PC 0x100 and 0x180 share index 0; 0x104 is index 1; 0x108 is index 2.
// -----------------------------------------------------------------------------
module tb_branch_predictor_2bit;

   logic        clk;
   logic        rst;
   logic        bp_enable;
   logic        stall;
   logic        flush;
   logic [31:0] pc_guess;
   logic        is_br_guess;
   logic        br_pred_taken;
   logic        br_pred_taken_q;
   logic [31:0] pc_check;
   logic        is_br_check;
   logic        br_taken_check;
   logic        mispredict;
   logic        cnt_clr;
   logic [31:0] br_instr_counter;
   logic [31:0] correct_br_counter;

   int n_checks;
   int n_errors;

   branch_predictor_2bit #(.LINES(32), .IDX_LSB(2)) dut (
      .clk                (clk),
      .rst                (rst),
      .bp_enable          (bp_enable),
      .stall              (stall),
      .flush              (flush),
      .pc_guess           (pc_guess),
      .is_br_guess        (is_br_guess),
      .br_pred_taken      (br_pred_taken),
      .br_pred_taken_q    (br_pred_taken_q),
      .pc_check           (pc_check),
      .is_br_check        (is_br_check),
      .br_taken_check     (br_taken_check),
      .mispredict         (mispredict),
      .cnt_clr            (cnt_clr),
      .br_instr_counter   (br_instr_counter),
      .correct_br_counter (correct_br_counter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One rising edge, return on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic guess_at(input logic [31:0] pc);
      pc_guess    = pc;
      is_br_guess = 1'b1;
      #1;
   endtask

   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      bp_enable      = 1'b0;
      stall          = 1'b0;
      flush          = 1'b0;
      pc_guess       = '0;
      is_br_guess    = 1'b0;
      pc_check       = '0;
      is_br_check    = 1'b0;
      br_taken_check = 1'b0;
      cnt_clr        = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // --- reset state
      bp_enable = 1'b1;
      guess_at(32'h100);
      chk("rst_guess",   {31'd0, br_pred_taken},   32'd0);
      chk("rst_pred_q",  {31'd0, br_pred_taken_q}, 32'd0);
      chk("rst_instr",   br_instr_counter,         32'd0);
      chk("rst_correct", correct_br_counter,       32'd0);

      // --- training 01 -> 10 -> 11 with pred_q held at 0
      is_br_guess    = 1'b0;
      pc_check       = 32'h100;
      is_br_check    = 1'b1;
      br_taken_check = 1'b1;
      step();
      step();
      is_br_check = 1'b0;
      guess_at(32'h100);
      chk("train_11_guess", {31'd0, br_pred_taken}, 32'd1);
      chk("train_instr",    br_instr_counter,       32'd2);
      chk("train_correct",  correct_br_counter,     32'd0);

      // two more taken (stays 11), then one not-taken (10, still taken)
      is_br_guess = 1'b0;
      is_br_check = 1'b1;
      step();
      step();
      br_taken_check = 1'b0;
      step();
      is_br_check = 1'b0;
      guess_at(32'h100);
      chk("sat_10_guess", {31'd0, br_pred_taken}, 32'd1);
      chk("sat_instr",    br_instr_counter,       32'd5);
      chk("sat_correct",  correct_br_counter,     32'd1);

      // --- carried guess 1, resolved not-taken -> mispredict
      step();                                   // pred_q <= 1
      chk("pipe_pred_q", {31'd0, br_pred_taken_q}, 32'd1);
      is_br_guess    = 1'b0;
      is_br_check    = 1'b1;
      br_taken_check = 1'b0;
      #1;
      chk("mis_wrong", {31'd0, mispredict}, 32'd1);
      step();                                   // entry 10 -> 01
      chk("mis_instr",   br_instr_counter,   32'd6);
      chk("mis_correct", correct_br_counter, 32'd1);

      // retrain to 10 (pred_q 0 vs taken: wrong), then carry 1 and resolve taken
      br_taken_check = 1'b1;
      step();                                   // 01 -> 10, counters 7/1
      is_br_check = 1'b0;
      guess_at(32'h100);
      step();                                   // pred_q <= 1
      is_br_guess = 1'b0;
      is_br_check = 1'b1;
      #1;
      chk("hit_mis", {31'd0, mispredict}, 32'd0);
      step();                                   // 10 -> 11, counters 8/2
      chk("hit_instr",   br_instr_counter,   32'd8);
      chk("hit_correct", correct_br_counter, 32'd2);

      // --- stall freezes everything; entry 0 is 11, pred_q set to 1
      is_br_check = 1'b0;
      guess_at(32'h100);
      step();
      stall          = 1'b1;
      cnt_clr        = 1'b1;
      is_br_check    = 1'b1;
      br_taken_check = 1'b0;
      pc_check       = 32'h100;
      is_br_guess    = 1'b0;
      repeat (3) step();
      chk("stall_pred_q",  {31'd0, br_pred_taken_q}, 32'd1);
      chk("stall_instr",   br_instr_counter,         32'd8);
      chk("stall_correct", correct_br_counter,       32'd2);
      stall       = 1'b0;
      cnt_clr     = 1'b0;
      is_br_check = 1'b0;
      guess_at(32'h100);
      chk("stall_table", {31'd0, br_pred_taken}, 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_pred_q", {31'd0, br_pred_taken_q}, 32'd0);

      // --- aliasing: 0x180 shares entry 0 (11)
      guess_at(32'h180);
      chk("alias_guess", {31'd0, br_pred_taken}, 32'd1);

      // --- same-cycle guess and update of index 1 (01 -> 10)
      pc_check       = 32'h104;
      is_br_check    = 1'b1;
      br_taken_check = 1'b1;
      guess_at(32'h104);
      chk("same_cyc_old", {31'd0, br_pred_taken}, 32'd0);
      step();                                   // counters 9/2
      is_br_check = 1'b0;
      #1;
      chk("same_cyc_new", {31'd0, br_pred_taken}, 32'd1);

      // --- bp_enable=0: clear, then N,N,T,N,T at index 1
      bp_enable = 1'b0;
      cnt_clr   = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_instr",   br_instr_counter,   32'd0);
      chk("clr_correct", correct_br_counter, 32'd0);
      guess_at(32'h100);
      is_br_check = 1'b1;
      pc_check    = 32'h104;
      begin
         logic [4:0] outcomes;
         outcomes = 5'b10100;                   // applied LSB first: N,N,T,N,T
         for (int i = 0; i < 5; i++) begin
            br_taken_check = outcomes[i];
            #1;
            chk("dis_guess", {31'd0, br_pred_taken}, 32'd0);
            chk("dis_mis",   {31'd0, mispredict},    32'd0);
            step();
         end
      end
      is_br_check = 1'b0;
      chk("dis_instr",   br_instr_counter,   32'd5);
      chk("dis_correct", correct_br_counter, 32'd3);
      bp_enable = 1'b1;
      guess_at(32'h104);
      chk("dis_frozen1", {31'd0, br_pred_taken}, 32'd1);
      guess_at(32'h100);
      chk("dis_frozen0", {31'd0, br_pred_taken}, 32'd1);

      // --- clear beats a same-cycle increment; pred_q becomes 1 here
      cnt_clr        = 1'b1;
      is_br_check    = 1'b1;
      pc_check       = 32'h108;
      br_taken_check = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_vs_inc_instr",   br_instr_counter,   32'd0);
      chk("clr_vs_inc_correct", correct_br_counter, 32'd0);

      // --- wrap: preload branch count to all-ones, resolve one correct branch
      is_br_guess = 1'b0;
      is_br_check = 1'b0;
      force dut.br_instr_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.br_instr_cnt_q;
      #1;
      chk("preload", br_instr_counter, 32'hFFFF_FFFF);
      is_br_check    = 1'b1;
      br_taken_check = 1'b1;                    // pred_q is 1 -> correct
      step();
      is_br_check = 1'b0;
      chk("wrap_instr",   br_instr_counter,   32'd0);
      chk("wrap_correct", correct_br_counter, 32'd1);

      // --- async reset mid-operation; entry 0 is 11 and index 1 is 10
      guess_at(32'h100);
      step();                                   // pred_q <= 1
      rst = 1'b1;
      #1;
      chk("arst_guess",   {31'd0, br_pred_taken},   32'd0);
      chk("arst_pred_q",  {31'd0, br_pred_taken_q}, 32'd0);
      chk("arst_instr",   br_instr_counter,         32'd0);
      chk("arst_correct", correct_br_counter,       32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion, expected finish before 100000ns");
      $fatal(1);
   end

endmodule

// File: doc/branch_predictor_2bit.md
Name: branch_predictor_2bit

Overview:
- Dynamic branch predictor for the 3-stage RISC-V core.
- Provides a same-cycle taken/not-taken guess for the branch in stage 1 (fetch/decode), from a table of 2-bit saturating counters indexed by PC.
- Carries that guess into stage 2 (execute) as br_pred_taken_q, and trains the table when stage 2 resolves the branch.
- Maintains the branch-instruction and correct-prediction counters that the MMIO read path exposes at 0x8000001c and 0x80000020.

Parameters:
- LINES, 32, number of table entries; power of 2, minimum 2.
- IDX_LSB, 2, lowest PC bit used for the index; the index is pc[IDX_LSB +: log2(LINES)].

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bp_enable  input  1  prediction enable; 0 forces not-taken guesses and freezes training.
- stall  input  1  pipeline hold; 1 freezes every register in this block.
- flush  input  1  stage-1 instruction is being killed (redirect).
- pc_guess  input  32  PC of the stage-1 instruction.
- is_br_guess  input  1  stage-1 instruction is a conditional branch.
- br_pred_taken  output  1  combinational guess for stage 1.
- br_pred_taken_q  output  1  registered guess belonging to the stage-2 instruction.
- pc_check  input  32  PC of the stage-2 instruction.
- is_br_check  input  1  stage-2 instruction is a conditional branch.
- br_taken_check  input  1  resolved outcome of the stage-2 branch.
- mispredict  output  1  combinational; the stage-2 guess was wrong.
- cnt_clr  input  1  synchronous clear of both counters (MMIO write to 0x80000018).
- br_instr_counter  output  32  number of branches resolved.
- correct_br_counter  output  32  number of branches whose guess matched the outcome.

Behaviour:
- Reset (async, rst=1):
  - all table entries set to 2'b01 (weakly not-taken);
  - br_pred_taken_q=0, br_instr_counter=0, correct_br_counter=0.
  - Reset asserted mid-operation discards any in-flight update; the combinational outputs follow the reset state immediately.
- Guess (combinational):
  - br_pred_taken = bp_enable & is_br_guess & table[idx(pc_guess)][1].
  - The guess always reads the pre-edge table value. There is no bypass from a same-cycle update to the same index.
- Guess pipeline register, evaluated on each rising edge:
  - if stall=1: br_pred_taken_q holds;
  - else if flush=1: br_pred_taken_q <= 0;
  - else: br_pred_taken_q <= br_pred_taken.
  - stall has priority over flush.
- mispredict = bp_enable & is_br_check & (br_taken_check != br_pred_taken_q).
- Training, on an edge with stall=0, bp_enable=1 and is_br_check=1, applied to entry idx(pc_check):
  - taken: counter+1, saturating at 3.
  - not taken: counter-1, saturating at 0.
  - States 00/01 predict not-taken; states 10/11 predict taken.
  - At most one entry changes per cycle.
  - Aliased PCs share an entry; this is intended.
- Counters, on an edge with stall=0:
  - if cnt_clr=1: both counters <= 0. Clear beats increment even when is_br_check=1 in the same cycle.
  - else if is_br_check=1: br_instr_counter+1, and correct_br_counter+1 when br_taken_check == br_pred_taken_q.
  - Counting happens regardless of bp_enable. With bp_enable=0, br_pred_taken_q is 0, so only not-taken branches count as correct.
  - Both counters wrap modulo 2^32 with no saturation.
  - With stall=1, cnt_clr is ignored; the core holds the store until the stall ends.
- Latency:
  - br_pred_taken is available in the same cycle as pc_guess.
  - A training update is visible to a guess in the cycle after the update edge.
- No X propagation is allowed: the table is fully reset, so there is no uninitialised read.

Test Plan:
- Reset, then pc_guess=0x100, is_br_guess=1, bp_enable=1 -> br_pred_taken=0; both counters read 0; br_pred_taken_q=0.
- Resolve the branch at pc_check=0x100 as taken for 2 consecutive cycles -> entry goes 01→10→11; the next guess at 0x100 is 1. Two further taken resolves leave the entry at 11; one not-taken resolve gives 10, still predicting taken.
- Guess 1 at pc 0x100 registered into br_pred_taken_q, then resolve with br_taken_check=0 -> mispredict=1, br_instr_counter+1, correct_br_counter unchanged. With br_taken_check=1 instead -> mispredict=0 and both counters +1.
- stall=1 for 3 cycles with is_br_check=1 and cnt_clr=1 -> table, br_pred_taken_q and both counters are unchanged. Then flush=1 with stall=0 -> br_pred_taken_q=0.
- LINES=32: pcs 0x100 and 0x180 alias (same idx) -> training 0x100 to 11 makes the guess for 0x180 equal 1. A same-cycle guess/update to one index returns the old value.
- bp_enable=0, 5 branches resolved (3 not-taken, 2 taken) -> br_pred_taken always 0 and the table unchanged; br_instr_counter=5, correct_br_counter=3. Then cnt_clr=1 together with is_br_check=1 -> both counters read 0 next cycle. Preload br_instr_counter to 0xFFFFFFFF, resolve one branch -> it wraps to 0.
